// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk by 4 into a pixel strobe and runs the
// horizontal/vertical raster counters with registered, glitch-free syncs.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync
);

  localparam int unsigned CW      = 10;
  localparam int unsigned DW      = 2;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DISP     = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_DISP     = CW'(V_DISPLAY);
  localparam logic [CW-1:0] H_SYNC_LO  = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_HI  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_LO  = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_HI  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(3);
  localparam logic          VIDEO_RST  = (H_DISPLAY > 0) && (V_DISPLAY > 0);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          p_tick_q, p_tick_d;
  logic          video_on_q, video_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          adv_c;

  // Counters step on the edge that ends the divider's terminal state.
  assign adv_c = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;

    if (adv_c) begin
      if (h_q >= H_LAST) begin
        h_d = '0;
        v_d = (v_q >= V_LAST) ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
        // A stray out-of-range row is pulled back even mid-line.
        if (v_q > V_LAST) begin
          v_d = '0;
        end
      end
    end

    // Outputs are registered from next-state values so they align with x/y.
    p_tick_d   = (div_d == DIV_LAST);
    video_on_d = (h_d < H_DISP) && (v_d < V_DISP);
    hsync_d    = ((h_d >= H_SYNC_LO) && (h_d <= H_SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = ((v_d >= V_SYNC_LO) && (v_d <= V_SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      p_tick_q   <= 1'b0;
      video_on_q <= VIDEO_RST;
      hsync_q    <= ~SYNC_ACTIVE;
      vsync_q    <= ~SYNC_ACTIVE;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      p_tick_q   <= p_tick_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign p_tick   = p_tick_q;
  assign x        = h_q;
  assign y        = v_q;
  assign video_on = video_on_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal retrace width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical retrace width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_ACTIVE, default 0, the logic level of hsync/vsync during retrace.
REQ-010 The block SHALL have port clk, input, 1, 100 MHz system clock.
REQ-011 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 The block SHALL have port p_tick, output, 1, 25 MHz pixel-enable strobe.
REQ-013 The block SHALL have port x, output, 10, current pixel column (h_count).
REQ-014 The block SHALL have port y, output, 10, current pixel row (v_count).
REQ-015 The block SHALL have port video_on, output, 1, high when (x,y) lies in the visible area.
REQ-016 The block SHALL have port hsync, output, 1, registered horizontal sync.
REQ-017 The block SHALL have port vsync, output, 1, registered vertical sync.
REQ-018 The block SHALL use one clock (clk), with reset synchronous and active-high; no other clock or async reset is permitted.

Function
REQ-019 The block SHALL derive p_tick from a 2-bit free-running divider counting 0,1,2,3,0; p_tick is 1 exactly when the divider equals 3.
REQ-020 The block SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-021 The block SHALL advance h_count and v_count only on clk edges where p_tick is 1; all other edges hold them.
REQ-022 The block SHALL wrap h_count from H_TOTAL-1 to 0, and otherwise increment it by 1.
REQ-023 The block SHALL increment v_count only on the edge where h_count wraps, and wrap v_count from V_TOTAL-1 to 0 on that same edge.
REQ-024 The block SHALL drive x = h_count and y = v_count directly from registers, with no added latency.
REQ-025 The block SHALL drive video_on = (h_count < H_DISPLAY) && (v_count < V_DISPLAY), combinationally from the counter registers.
REQ-026 The block SHALL assert hsync = SYNC_ACTIVE while h_count is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] ([656,751]).
REQ-027 The block SHALL assert vsync = SYNC_ACTIVE while v_count is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] ([490,491]).
REQ-028 The block SHALL register hsync/vsync from the next counter values, so the sync outputs change on the same edge as x/y and are glitch-free.
REQ-029 The block SHALL use a line period of 3200 clk and a frame period of 1,680,000 clk.
REQ-030 The block SHALL make x==0 && y==481 occur exactly once per frame, lasting 4 clk; this is the downstream refresh point.
REQ-031 The block SHALL never let counters exceed H_TOTAL-1 / V_TOTAL-1; any out-of-range value forces a wrap to 0 on the next p_tick.

Reset
REQ-032 When reset is sampled high, the block SHALL on that edge set divider=0, h_count=0, v_count=0, hsync=~SYNC_ACTIVE and vsync=~SYNC_ACTIVE.
REQ-033 During and after reset, outputs SHALL be p_tick=0, x=0, y=0, video_on=1, and hsync/vsync inactive (1 at default).
REQ-034 The first p_tick after reset release SHALL occur 3 clk after the first non-reset edge, and x SHALL then step to 1.
REQ-035 Reset asserted mid-frame SHALL override counting on the same edge; no partial line or sync pulse continues.

Verification
REQ-036 Release reset and count clk: p_tick is high on cycles 3,7,11,…; x=1 after cycle 4; x=639 at cycle 2559, and video_on falls when x=640.
REQ-037 Within line 0: hsync falls when x=656 and rises when x=752, a low width of 384 clk; the next line starts 3200 clk after line start, with y=1.
REQ-038 Run a full frame: vsync is low only for y=490..491 (6400 clk); y wraps from 524 to 0 at 1,680,000 clk; video_on is low for all y>=480.
REQ-039 Detect x==0 && y==481: it is seen exactly once per frame for 4 consecutive clk.
REQ-040 Assert reset at x=300, y=200 for 1 clk: the next cycle gives x=0, y=0, hsync=vsync=1, p_tick=0, and counting resumes per REQ-034.
REQ-041 Set SYNC_ACTIVE=1: sync pulses are high over the same windows, and the reset level of hsync/vsync is 0.
